// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle CPU's data port.
// Accepts a request, waits WAIT_STATES cycles, reads the addressed word, then either
// formats a sub-word/word load or performs a read-modify-write store, and finally
// pulses ready for one cycle.
//
// Ports:
//   clk     - clock, all state on the rising edge
//   reset   - synchronous active-high reset
//   req     - access request (sampled only when idle)
//   mem_w   - 1 = store, 0 = load
//   addr    - byte address; bits above DEPTH_LOG2+1 are ignored (aliasing)
//   wdata   - store data (low byte/half used for sub-word stores)
//   dm_type - 000 word, 001 half, 010 half-unsigned, 011 byte, 100 byte-unsigned
//   rdata   - formatted load result, held until the next load or fault completes
//   ready   - one-cycle completion pulse
//   err     - access fault, valid only while ready is high
module dmem_responder #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  dm_type,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int unsigned AddrW = DEPTH_LOG2 + 2;

  typedef enum logic [2:0] {StIdle, StWait, StRead, StMerge, StDone} state_e;

  state_e            state_q;
  logic [AddrW-1:0]  addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        type_q;
  logic              mem_w_q;
  logic [3:0]        cnt_q;
  logic [31:0]       rd_word_q;
  logic [31:0]       rdata_q;
  logic              ready_q;
  logic              err_q;

  logic [31:0]       mem_q [1 << DEPTH_LOG2];

  logic [DEPTH_LOG2-1:0] idx;
  logic                  fault;
  logic [31:0]           lane_word;
  logic [31:0]           load_val;
  logic [31:0]           store_word;
  logic                  ram_we;

  // Upper address bits only select aliases of the same word.
  logic unused_addr;
  assign unused_addr = ^addr[31:AddrW];

  assign idx = addr_q[AddrW-1:2];

  always_comb begin
    fault      = 1'b0;
    load_val   = 32'h0;
    store_word = rd_word_q;
    // Selected lane shifted down to bit 0.
    lane_word  = rd_word_q >> {addr_q[1:0], 3'b000};
    case (type_q)
      3'b000: begin
        fault      = (addr_q[1:0] != 2'b00);
        load_val   = rd_word_q;
        store_word = wdata_q;
      end
      3'b001, 3'b010: begin
        fault    = addr_q[0];
        load_val = {((type_q == 3'b001) ? {16{lane_word[15]}} : 16'h0), lane_word[15:0]};
        store_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      3'b011, 3'b100: begin
        load_val = {((type_q == 3'b011) ? {24{lane_word[7]}} : 24'h0), lane_word[7:0]};
        store_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      default: fault = 1'b1;
    endcase
  end

  // Reset on the commit edge cancels the write.
  assign ram_we = (state_q == StMerge) && mem_w_q && !fault && !reset;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem_q[idx] <= store_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
      type_q    <= 3'b000;
      mem_w_q   <= 1'b0;
      cnt_q     <= 4'd0;
      rd_word_q <= 32'h0;
      rdata_q   <= 32'h0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req) begin
            addr_q  <= addr[AddrW-1:0];
            wdata_q <= wdata;
            type_q  <= dm_type;
            mem_w_q <= mem_w;
            if (WAIT_STATES > 0) begin
              cnt_q   <= 4'(WAIT_STATES - 1);
              state_q <= StWait;
            end else begin
              state_q <= StRead;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q <= StRead;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StRead: begin
          rd_word_q <= mem_q[idx];
          state_q   <= StMerge;
        end
        StMerge: begin
          if (fault) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b1;
          end else if (!mem_w_q) begin
            rdata_q <= load_val;
          end
          ready_q <= 1'b1;
          state_q <= StDone;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the single-cycle CPU's data port. It accepts the CPU's data requests (`CPU_MIO`, `mem_w`, `Addr_out`, `Data_out`, `DMType`) and returns `Data_in` plus a `MIO_ready` handshake after a fixed, parameterised latency. It owns a word-organised RAM and performs byte and halfword lane alignment: read-modify-write for sub-word stores, sign or zero extension for sub-word loads. It sits between the CPU core and the top-level bus, in place of a combinational data memory.

## Interface
- `DEPTH_LOG2`, default 10: RAM holds 2^DEPTH_LOG2 32-bit words; word index is `addr[DEPTH_LOG2+1:2]`.
- `WAIT_STATES`, default 1: extra wait cycles inserted before the RAM read (0–15).
- `clk  in  1`: single clock; all state updates on the rising edge.
- `reset  in  1`: synchronous, active-high.
- `req  in  1`: access request, driven from `CPU_MIO`.
- `mem_w  in  1`: 1 = store, 0 = load.
- `addr  in  32`: byte address, from `Addr_out`.
- `wdata  in  32`: store data, from `Data_out`; the low byte or halfword is used for sub-word stores.
- `dm_type  in  3`: access type; encodings are word 000, half 001, half-unsigned 010, byte 011, byte-unsigned 100; 101–111 are invalid.
- `rdata  out  32`: formatted load result, drives `Data_in`.
- `ready  out  1`: completion pulse, drives `MIO_ready`.
- `err  out  1`: access fault, valid while `ready`=1.

## Operation
- **FSM states:** IDLE, WAIT, READ, MERGE, DONE.
- **IDLE:**
  - If `req`=1, latch `addr`, `wdata`, `dm_type` and `mem_w`.
  - Go to WAIT if `WAIT_STATES`>0 (load the wait counter with `WAIT_STATES`-1); otherwise go to READ.
- **WAIT:** decrement the counter; go to READ when it reaches 0.
- **READ:** register `mem[idx]` into `rd_word`; go to MERGE.
- **MERGE, fault check:** the access faults if any of the following holds:
  - word access with `addr[1:0]`≠0;
  - half access with `addr[0]`=1;
  - invalid `dm_type`.
- **MERGE, load (no fault):** `rdata` ← the selected lane of `rd_word`:
  - byte lane is `addr[1:0]`; half lane is `addr[1]`;
  - signed types sign-extend bit 7 or bit 15; unsigned types zero-extend.
- **MERGE, store (no fault):** `mem[idx]` ← `rd_word` with the target lane(s) replaced by `wdata[7:0]` (byte) or `wdata[15:0]` (half); a word store writes all of `wdata`. `rdata` is unchanged.
- **MERGE, fault:** no RAM write; `rdata` ← 0; `err` is set.
- **MERGE → DONE** unconditionally.
- **DONE:** `ready`=1 for exactly one cycle; go to IDLE.
- **Request handling:**
  - `req` is sampled only in IDLE; changes to `req` after acceptance do not affect the transaction in flight.
  - The latched fields are used for the whole transaction; input changes after acceptance are ignored.
- **Address bits** above `DEPTH_LOG2+1` are ignored, so addresses alias modulo the RAM size.

## Timing
- **Latency:** `req` sampled high in cycle c → `ready`=1 in cycle c+`WAIT_STATES`+3 (c+4 at the default).
- **Store commit:** the RAM write happens on the MERGE→DONE edge, so a load issued after `ready` observes the store.
- **Back-to-back requests:** DONE returns to IDLE; a `req` held high is accepted in that IDLE cycle. The minimum request period is `WAIT_STATES`+4 cycles.
- **Output registers:**
  - `ready` and `err` are registered state outputs; `err` is valid only in DONE and is 0 elsewhere.
  - `rdata` holds its value until the next load or fault completes.
- **Reset values:** state=IDLE, `ready`=0, `err`=0, `rdata`=0, wait counter=0. RAM contents are not cleared.
- **Reset mid-transaction:** the transaction is abandoned. If reset is asserted in any cycle before the MERGE edge, no RAM write occurs. Reset takes precedence over all other transitions.

## Test plan
- **Word store/load:** word store `addr`=0x10, `wdata`=0xDEADBEEF, then word load 0x10 → `rdata`=0xDEADBEEF, `err`=0, `ready` high exactly 4 cycles after each `req` (`WAIT_STATES`=1).
- **Byte load sign/zero extension:** with 0x10=0xDEADBEEF, signed byte load 0x11 → 0xFFFFFFBE; unsigned byte load 0x11 → 0x000000BE; signed half load 0x12 → 0xFFFFDEAD; unsigned half load 0x12 → 0x0000DEAD.
- **Sub-word read-modify-write:**
  - byte store 0x13, `wdata`=0x12345677 → word 0x10 reads 0x77ADBEEF;
  - then half store 0x10, `wdata`=0xAAAA1234 → word 0x10 reads 0x77AD1234.
- **Faults:**
  - word load 0x12 → `err`=1, `rdata`=0;
  - half store 0x11 → `err`=1, and word 0x10 is unchanged afterwards;
  - `dm_type`=3'b111 → `err`=1.
- **Reset and aliasing:**
  - reset asserted in the READ cycle of a store → no `ready`, outputs return to reset values, and a subsequent load shows the old data;
  - address 0x1010 aliases 0x10 at `DEPTH_LOG2`=10.
- **Held request:** `req` held high continuously → `ready` pulses every 5 cycles; with `WAIT_STATES`=0, latency is 3 cycles and the pulse period is 4 cycles.
